// File: rtl/bcd_conv_scheduler.sv
// bcd_conv_scheduler: round-robin time-sharing of one serial binary-to-BCD
// converter among N_CH requesters. Each granted value is clamped to 0..99,
// handed to the converter, and the BCD result is captured into a per-channel
// register with a one-cycle ack pulse.
// Optional feature macro: BCD_SKIP_UNCHANGED_EN -- skip the conversion when
// the granted value equals the last value converted for that channel.
module bcd_conv_scheduler #(
  parameter int N_CH     = 3,
  parameter int CONV_LAT = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     req,
  input  logic [7*N_CH-1:0]   bin_in,
  output logic [N_CH-1:0]     ack,
  output logic [8*N_CH-1:0]   bcd_out,
  output logic                range_err,
  output logic                busy,
  output logic                conv_start,
  output logic [6:0]          conv_bin,
  input  logic [7:0]          conv_bcd
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(CONV_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_LAT - 1);
  localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(N_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_CAPTURE
  } state_t;

  state_t            state_reg;
  logic [IDX_W-1:0]  rr_ptr_reg;
  logic [IDX_W-1:0]  grant_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              clamp_reg;
  logic [N_CH-1:0]   ack_reg;
  logic              range_err_reg;
  logic              conv_start_reg;
  logic [6:0]        conv_bin_reg;
  logic [7:0]        bcd_reg [N_CH];

  // Per-channel views of the packed input/output buses
  logic [6:0]        bin_arr [N_CH];

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign bin_arr[gi]          = bin_in[7*gi +: 7];
      assign bcd_out[8*gi +: 8]   = bcd_reg[gi];
    end
  endgenerate

  // Round-robin search starting just after the last served channel
  logic              grant_found;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  cand;
  logic [6:0]        raw_val;
  logic              grant_over;
  logic [6:0]        grant_val;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= N_CH; i++) begin
      cand = IDX_W'((int'(rr_ptr_reg) + i) % N_CH);
      if (!grant_found && req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    raw_val    = bin_arr[grant_idx];
    grant_over = (raw_val > 7'd99);
    grant_val  = grant_over ? 7'd99 : raw_val;
  end

`ifdef BCD_SKIP_UNCHANGED_EN
  // Last clamped value converted per channel, used to skip repeat work
  logic [6:0]        last_val_reg [N_CH];
  logic [N_CH-1:0]   last_valid_reg;
  logic              skip_hit;

  assign skip_hit = last_valid_reg[grant_idx] &&
                    (last_val_reg[grant_idx] == grant_val);
`endif

  // Scheduler FSM: arbitrate, start the converter, wait out its latency, capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      rr_ptr_reg     <= PTR_INIT;
      grant_reg      <= '0;
      cnt_reg        <= '0;
      clamp_reg      <= 1'b0;
      ack_reg        <= '0;
      range_err_reg  <= 1'b0;
      conv_start_reg <= 1'b0;
      conv_bin_reg   <= '0;
      for (int k = 0; k < N_CH; k++) begin
        bcd_reg[k] <= '0;
      end
`ifdef BCD_SKIP_UNCHANGED_EN
      last_valid_reg <= '0;
      for (int k = 0; k < N_CH; k++) begin
        last_val_reg[k] <= '0;
      end
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_found) begin
            grant_reg <= grant_idx;
            clamp_reg <= grant_over;
`ifdef BCD_SKIP_UNCHANGED_EN
            if (skip_hit) begin
              // Result already held in bcd_reg: acknowledge without converting
              ack_reg[grant_idx] <= 1'b1;
              range_err_reg      <= grant_over;
              rr_ptr_reg         <= grant_idx;
              state_reg          <= ST_CAPTURE;
            end else
`endif
            begin
              conv_start_reg <= 1'b1;
              conv_bin_reg   <= grant_val;
              state_reg      <= ST_START;
            end
          end
        end
        ST_START: begin
          conv_start_reg <= 1'b0;
          cnt_reg        <= CNT_LOAD;
          state_reg      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_reg == '0) begin
            bcd_reg[grant_reg] <= conv_bcd;
            ack_reg[grant_reg] <= 1'b1;
            range_err_reg      <= clamp_reg;
            rr_ptr_reg         <= grant_reg;
            state_reg          <= ST_CAPTURE;
`ifdef BCD_SKIP_UNCHANGED_EN
            last_val_reg[grant_reg]   <= conv_bin_reg;
            last_valid_reg[grant_reg] <= 1'b1;
`endif
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        ST_CAPTURE: begin
          ack_reg       <= '0;
          range_err_reg <= 1'b0;
          state_reg     <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack        = ack_reg;
  assign range_err  = range_err_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign conv_start = conv_start_reg;
  assign conv_bin   = conv_bin_reg;

endmodule
